// File: rtl/ldl_fifo_pkg.sv
// Shared types and constants for the LDL FIFO read-side stream drain.
package ldl_fifo_pkg;

    // Local buffer occupancy, 0..2 words.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX    = 2'd2;
    localparam int   XFER_CNT_W = 16;

endpackage

// File: rtl/ldl_stream_skid2.sv
// Two-entry register buffer feeding a valid/ready stream.
// s0 always drives m_data; s1 is the skid slot used only while s0 is held.
module ldl_stream_skid2
    import ldl_fifo_pkg::*;
#(
    parameter int DW = 8
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cap,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output occ_t          occ,
    output logic          m_valid,
    output logic [DW-1:0] m_data
);

    occ_t          occ_q, occ_d;
    occ_t          occ_after_pop;
    logic [DW-1:0] s0_q, s0_d;
    logic [DW-1:0] s1_q, s1_d;

    // Pop shifts s1 forward; a captured word fills the first free slot after the pop.
    always_comb begin
        s0_d          = s0_q;
        s1_d          = s1_q;
        occ_after_pop = occ_q - occ_t'(pop);
        if (pop && occ_q == OCC_MAX) begin
            s0_d = s1_q;
        end
        if (cap) begin
            if (occ_after_pop == '0) begin
                s0_d = din;
            end else begin
                s1_d = din;
            end
        end
        occ_d = occ_after_pop + occ_t'(cap);
    end

    // Buffer registers; reset drops anything held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
            s0_q  <= '0;
            s1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
        end
    end

    assign occ     = occ_q;
    assign m_valid = (occ_q != '0);
    assign m_data  = s0_q;

    // The credit logic upstream must never deliver a word into a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(cap && !pop && occ_q == OCC_MAX));

endmodule

// File: rtl/ldl_fifo_rd_stream.sv
// Read-side drain for the LDL FIFOs: issues re to the FIFO read port and
// presents the words as a valid/ready stream from a 2-entry buffer.
// AHEAD=1: show-ahead FIFO, dout captured in the cycle re is high.
// AHEAD=0: registered-read FIFO, dout captured the cycle after re (pend).
// Optional feature macro: LDL_FIFO_RD_STAT_EN adds the saturating xfer_cnt port.
module ldl_fifo_rd_stream
    import ldl_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AHEAD = 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [DW-1:0]         dout,
    output logic                  re,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW-1:0]         m_data,
    output logic [1:0]            lvl
`ifdef LDL_FIFO_RD_STAT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    occ_t       occ;
    logic       pop;
    logic       cap;
    logic       pend_q, pend_d;
    logic [2:0] credit;

    assign pop = m_valid & m_ready;

    // Words held plus the one in flight from the FIFO; a pop this cycle frees a
    // slot, so m_ready feeds re combinationally to keep 1 word/cycle.
    assign credit = {1'b0, occ} + {2'b00, pend_q};
    assign re     = ~empty & ~rst & ((credit < {1'b0, OCC_MAX}) | pop);
    assign cap    = (AHEAD != 0) ? re : pend_q;

    // A registered-read FIFO presents the word one cycle after re.
    always_comb begin
        pend_d = (AHEAD != 0) ? 1'b0 : re;
    end

    // In-flight read marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    ldl_stream_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap     (cap),
        .pop     (pop),
        .din     (dout),
        .occ     (occ),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

    assign lvl = occ;

`ifdef LDL_FIFO_RD_STAT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Completed handshakes, saturating at all-ones.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (pop && xfer_cnt_q != '1) begin
            xfer_cnt_d = xfer_cnt_q + {{(XFER_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_ldl_fifo_rd_stream.sv
// Bench for ldl_fifo_rd_stream: one show-ahead and one registered-read instance
// share stimulus; each has its own emulated FIFO and a queue-level model of
// the buffered words.
module tb_ldl_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst;
    logic m_ready;

    logic [1:0]      empty_v, re_v, m_valid_v;
    logic [1:0][7:0] dout_v, m_data_v;
    logic [1:0][1:0] lvl_v;
`ifdef LDL_FIFO_RD_STAT_EN
    logic [1:0][15:0] xfer_v;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ldl_fifo_rd_stream #(.DW(8), .AHEAD(1)) u_ahead (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty_v[0]),
        .dout    (dout_v[0]),
        .re      (re_v[0]),
        .m_valid (m_valid_v[0]),
        .m_ready (m_ready),
        .m_data  (m_data_v[0]),
        .lvl     (lvl_v[0])
`ifdef LDL_FIFO_RD_STAT_EN
        ,
        .xfer_cnt(xfer_v[0])
`endif
    );

    ldl_fifo_rd_stream #(.DW(8), .AHEAD(0)) u_regrd (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty_v[1]),
        .dout    (dout_v[1]),
        .re      (re_v[1]),
        .m_valid (m_valid_v[1]),
        .m_ready (m_ready),
        .m_data  (m_data_v[1]),
        .lvl     (lvl_v[1])
`ifdef LDL_FIFO_RD_STAT_EN
        ,
        .xfer_cnt(xfer_v[1])
`endif
    );

    // Emulated FIFO contents (index 0: show-ahead, index 1: registered read).
    logic [7:0] src_mem [2][1024];
    int         src_rd [2];
    int         src_wr [2];
    int         sb_rd  [2];
    // Model of the words the block must be holding.
    logic [7:0] hold_w [2][2];
    int         hold_n [2];
    logic       pend_m [2];
    logic [7:0] pend_w [2];
    logic       last_re[2];
    int         pops_m [2];
    // Statistics for literal checks.
    int         re_cnt [2];
    int         valid_cnt[2];
    int         max_lvl[2];
    int         first_valid[2];
    logic [7:0] out_mem[2][16];
    int         out_cyc[2][16];
    int         out_n  [2];
    int         cyc = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[inst%0d] cyc=%0d: got %0h expected %0h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        for (int i = 0; i < 2; i++) begin
            src_mem[i][src_wr[i] % 1024] = w;
            src_wr[i]++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            src_rd[i]  = src_wr[i];
            sb_rd[i]   = src_wr[i];
            hold_n[i]  = 0;
            pend_m[i]  = 1'b0;
            pend_w[i]  = 8'h00;
            last_re[i] = 1'b0;
            pops_m[i]  = 0;
            dout_v[i]  = 8'h00;
            empty_v[i] = 1'b1;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            re_cnt[i] = 0; valid_cnt[i] = 0; max_lvl[i] = 0;
            first_valid[i] = -1; out_n[i] = 0;
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic rdy);
        logic       ev, ep, er, cp;
        logic [7:0] front, cw;
        for (int i = 0; i < 2; i++) begin
            if (last_re[i] && src_rd[i] != src_wr[i]) begin
                if (i == 1) dout_v[1] = src_mem[1][src_rd[1] % 1024];
                src_rd[i]++;
            end
            last_re[i] = 1'b0;
            empty_v[i] = (src_rd[i] == src_wr[i]);
            if (i == 0) dout_v[0] = empty_v[0] ? 8'h00 : src_mem[0][src_rd[0] % 1024];
        end
        m_ready = rdy;
        #1;
        for (int i = 0; i < 2; i++) begin
            ev    = (hold_n[i] != 0);
            ep    = ev & rdy;
            er    = !empty_v[i] && (((hold_n[i] + int'(pend_m[i])) < 2) || ep);
            front = src_mem[i][src_rd[i] % 1024];
            check("re", i, re_v[i], er);
            check("m_valid", i, m_valid_v[i], ev);
            check("lvl", i, lvl_v[i], hold_n[i]);
            if (ev) check("m_data", i, m_data_v[i], hold_w[i][0]);
`ifdef LDL_FIFO_RD_STAT_EN
            check("xfer_cnt", i, xfer_v[i], (pops_m[i] > 65535) ? 65535 : pops_m[i]);
`endif
            if (re_v[i] === 1'b1) re_cnt[i]++;
            if (m_valid_v[i] === 1'b1) begin
                valid_cnt[i]++;
                if (first_valid[i] < 0) first_valid[i] = cyc;
            end
            if (int'(lvl_v[i]) > max_lvl[i]) max_lvl[i] = int'(lvl_v[i]);
            if (m_valid_v[i] === 1'b1 && rdy) begin
                check("order", i, m_data_v[i], src_mem[i][sb_rd[i] % 1024]);
                sb_rd[i]++;
                if (out_n[i] < 16) begin
                    out_mem[i][out_n[i]] = m_data_v[i];
                    out_cyc[i][out_n[i]] = cyc;
                end
                out_n[i]++;
            end
            if (ep) begin
                hold_w[i][0] = hold_w[i][1];
                hold_n[i]--;
                pops_m[i]++;
            end
            if (i == 0) begin
                cp = er; cw = front;
            end else begin
                cp = pend_m[1]; cw = pend_w[1];
                pend_m[1] = er;
                if (er) pend_w[1] = front;
            end
            if (cp && hold_n[i] < 2) begin
                hold_w[i][hold_n[i]] = cw;
                hold_n[i]++;
            end
            last_re[i] = re_v[i];
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int depth;
        rst     = 1'b1;
        m_ready = 1'b0;
        model_reset();
        clear_stats();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_m_valid", i, m_valid_v[i], 0);
            check("rst_lvl", i, lvl_v[i], 0);
            check("rst_re", i, re_v[i], 0);
            check("rst_m_data", i, m_data_v[i], 0);
`ifdef LDL_FIFO_RD_STAT_EN
            check("rst_xfer", i, xfer_v[i], 0);
`endif
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: preloaded A1..A8 streamed with m_ready held high.
        clear_stats();
        for (int k = 0; k < 8; k++) push(8'hA1 + 8'(k));
        c0 = cyc;
        for (int k = 0; k < 14; k++) cycle(1'b1);
        for (int i = 0; i < 2; i++) begin
            check("t1_count", i, out_n[i], 8);
            check("t1_latency", i, first_valid[i] - c0, (i == 0) ? 1 : 2);
            check("t1_back_to_back", i, out_cyc[i][7] - out_cyc[i][0], 7);
            check("t1_lvl_le1", i, max_lvl[i] <= 1, 1);
            for (int k = 0; k < 8; k++) check("t1_word", i, out_mem[i][k], 8'hA1 + 8'(k));
        end

        // 2: sink stalled, 8 words queued: exactly two reads, A1 held.
        clear_stats();
        for (int k = 0; k < 8; k++) push(8'hA1 + 8'(k));
        for (int k = 0; k < 10; k++) cycle(1'b0);
        for (int i = 0; i < 2; i++) begin
            check("t2_re_pulses", i, re_cnt[i], 2);
            check("t2_lvl", i, lvl_v[i], 2);
            check("t2_hold", i, m_data_v[i], 8'hA1);
        end
        cycle(1'b1);
        for (int i = 0; i < 2; i++) check("t2_next", i, m_data_v[i], 8'hA2);
        for (int k = 0; k < 20; k++) cycle(1'b1);
        for (int i = 0; i < 2; i++) check("t2_drained", i, sb_rd[i], src_wr[i]);

        // 3: FIFO empty throughout.
        clear_stats();
        for (int k = 0; k < 30; k++) cycle(1'($urandom_range(0, 1)));
        for (int i = 0; i < 2; i++) begin
            check("t3_no_re", i, re_cnt[i], 0);
            check("t3_no_valid", i, valid_cnt[i], 0);
        end

        // 4: toggling sink, random arrivals, then random sink.
        for (int k = 0; k < 900; k++) begin
            depth = src_wr[1] - src_rd[1];
            if (depth < 16 && $urandom_range(0, 1) == 1) push(8'($urandom));
            cycle((k < 600) ? ((k % 2) == 0) : 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 40; k++) cycle(1'b1);
        for (int i = 0; i < 2; i++) check("t4_no_loss", i, sb_rd[i], src_wr[i]);

        // 5: asynchronous reset with a full buffer.
        for (int k = 0; k < 4; k++) push(8'hC0 + 8'(k));
        for (int k = 0; k < 5; k++) cycle(1'b0);
        for (int i = 0; i < 2; i++) check("t5_pre_lvl", i, lvl_v[i], 2);
        m_ready = 1'b1;
        rst     = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("t5_m_valid", i, m_valid_v[i], 0);
            check("t5_lvl", i, lvl_v[i], 0);
            check("t5_re", i, re_v[i], 0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) push(8'hD0 + 8'(k));
        for (int k = 0; k < 12; k++) cycle(1'b1);
        for (int i = 0; i < 2; i++) check("t5_restart", i, sb_rd[i], src_wr[i]);

`ifdef LDL_FIFO_RD_STAT_EN
        // 6: counter saturation after 0x10000+5 pops, cleared by reset.
        for (int k = 0; k < 70000 && pops_m[1] < 65541; k++) begin
            depth = src_wr[1] - src_rd[1];
            if (depth < 6) push(8'($urandom));
            cycle(1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            check("t6_pops_reached", i, pops_m[i] >= 65541, 1);
            check("t6_saturated", i, xfer_v[i], 16'hFFFF);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("t6_rst_clear", i, xfer_v[i], 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
